chroma_resample: RTL and testbench

Parametrised chroma resampler. Converts a raster YCbCr 4:4:4 pixel stream into 4:4:4, 4:2:2, 4:2:0 or 4:0:0 output, with the format selected per frame. Sits between `rgb2yuv` and `mcu_buffer` in the JPEG ISP path. It succeeds the fixed 4:2:0 `subsample` stage and adds:
- run-time mode selection;
- rounded 2-tap and 4-tap chroma averaging instead of decimation;
- per-component valids consumable by a mode-aware MCU buffer.

---
 rtl/chroma_resample.sv | 188 ++++++++++++++++++
 tb/tb_chroma_resample.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_resample.sv
// Chroma resampler: 4:4:4 raster YCbCr in, 4:4:4 / 4:2:2 / 4:2:0 / 4:0:0 out.
// The format is latched at each frame start. Chroma is produced by rounded 2-tap
// (4:2:2) or 4-tap (4:2:0) averaging. The output is a single register stage with
// per-component valids.
module chroma_resample #(
  parameter int unsigned DW            = 8,
  parameter int unsigned SENSOR_X_SIZE = 720,
  parameter int unsigned SENSOR_Y_SIZE = 720,
  localparam int unsigned XW           = $clog2(SENSOR_X_SIZE),
  localparam int unsigned YW           = $clog2(SENSOR_Y_SIZE)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] yuv_in [2:0],
  input  logic          yuv_in_valid,
  output logic          yuv_in_hold,
  input  logic          frame_valid_in,
  input  logic          line_valid_in,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x_size_m1,
  input  logic [YW-1:0] y_size_m1,
  output logic [DW-1:0] yuv_out [2:0],
  output logic [2:0]    yuv_out_valid,
  input  logic          yuv_out_hold,
  output logic          eof_out,
  output logic [XW-1:0] yuv_out_pixel_count,
  output logic [YW-1:0] yuv_out_line_count
);

  localparam int unsigned SW = DW + 1;             // horizontal pair sum width
  localparam int unsigned LW = 2 * SW;             // line buffer word: {Cr sum, Cb sum}
  localparam int unsigned LD = SENSOR_X_SIZE / 2;  // one entry per horizontal pair
  localparam int unsigned AW = $clog2(LD);

  localparam logic [1:0] Mode444 = 2'd0;
  localparam logic [1:0] Mode422 = 2'd1;
  localparam logic [1:0] Mode420 = 2'd2;

  // Framing / coordinate state
  logic          fv_q;
  logic [1:0]    mode_q, mode_cur;
  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  logic          fv_rise, accept, x_last, y_last;

  // Chroma state: even-x sample of the current pair, line buffer read data
  logic [1:0][DW-1:0] c_in, c_even_q, c_even_d;
  logic [LW-1:0]      lb_mem [LD];
  logic [LW-1:0]      lb_rd_q, lb_wdata;
  logic [AW-1:0]      lb_addr;
  logic               lb_we, lb_re;

  logic [1:0][SW-1:0]   pair_sum;
  logic [1:0][DW-1:0]   avg2, avg4;
  logic [1:0][DW+1:0]   quad_sum;

  // Output register
  logic [2:0][DW-1:0] out_q, out_d;
  logic [2:0]         valid_q, valid_d;
  logic               eof_q, eof_d;
  logic [XW-1:0]      px_q, px_d;
  logic [YW-1:0]      ly_q, ly_d;

  assign c_in[0] = yuv_in[1];
  assign c_in[1] = yuv_in[2];

  assign yuv_out[0]          = out_q[0];
  assign yuv_out[1]          = out_q[1];
  assign yuv_out[2]          = out_q[2];
  assign yuv_out_valid       = valid_q;
  assign eof_out             = eof_q;
  assign yuv_out_pixel_count = px_q;
  assign yuv_out_line_count  = ly_q;

  // Accept, coordinates and mode; a pixel arriving on the frame-start cycle is (0,0)
  always_comb begin
    fv_rise     = frame_valid_in & ~fv_q;
    x_cur       = fv_rise ? '0 : x_q;
    y_cur       = fv_rise ? '0 : y_q;
    mode_cur    = fv_rise ? mode : mode_q;
    yuv_in_hold = yuv_out_hold & (|valid_q);
    accept      = yuv_in_valid & ~yuv_in_hold & frame_valid_in & line_valid_in;
    x_last      = (x_cur == x_size_m1);
    y_last      = (y_cur == y_size_m1);
    x_d         = x_cur;
    y_d         = y_cur;
    if (accept) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_cur + YW'(1);
      end else begin
        x_d = x_cur + XW'(1);
      end
    end
  end

  // Chroma arithmetic and line buffer control
  always_comb begin
    c_even_d = c_even_q;
    if (accept && !x_cur[0]) c_even_d = c_in;
    for (int ch = 0; ch < 2; ch++) begin
      pair_sum[ch] = {1'b0, c_even_q[ch]} + {1'b0, c_in[ch]};
      avg2[ch]     = DW'((pair_sum[ch] + SW'(1)) >> 1);
      quad_sum[ch] = (DW+2)'(lb_rd_q[ch*SW +: SW]) + (DW+2)'(pair_sum[ch]) + (DW+2)'(2);
      avg4[ch]     = DW'(quad_sum[ch] >> 2);
    end
    lb_wdata = {pair_sum[1], pair_sum[0]};
    lb_addr  = AW'(x_cur >> 1);
    // Write on even line odd x; read on odd line even x so data is ready at odd x
    lb_we    = accept && (mode_cur == Mode420) && !y_cur[0] && x_cur[0];
    lb_re    = accept && (mode_cur == Mode420) && y_cur[0] && !x_cur[0];
  end

  // Output register next state: load on accept, drop valids once consumed
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    eof_d   = eof_q;
    px_d    = px_q;
    ly_d    = ly_q;
    if (accept) begin
      out_d[0] = yuv_in[0];
      valid_d  = 3'b001;
      eof_d    = x_last & y_last;
      px_d     = x_cur;
      ly_d     = y_cur;
      unique case (mode_cur)
        Mode444: begin
          out_d[2:1] = c_in;
          valid_d    = 3'b111;
        end
        Mode422: begin
          if (x_cur[0]) begin
            out_d[2:1] = avg2;
            valid_d    = 3'b111;
          end
        end
        Mode420: begin
          if (x_cur[0] && y_cur[0]) begin
            out_d[2:1] = avg4;
            valid_d    = 3'b111;
          end
        end
        default: ;  // 4:0:0 never produces chroma
      endcase
    end else if (!yuv_out_hold) begin
      valid_d = '0;
      eof_d   = 1'b0;
    end
  end

  // Control, coordinate and output state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fv_q     <= 1'b0;
      mode_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      c_even_q <= '0;
      out_q    <= '0;
      valid_q  <= '0;
      eof_q    <= 1'b0;
      px_q     <= '0;
      ly_q     <= '0;
    end else begin
      fv_q     <= frame_valid_in;
      mode_q   <= mode_cur;
      x_q      <= x_d;
      y_q      <= y_d;
      c_even_q <= c_even_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      eof_q    <= eof_d;
      px_q     <= px_d;
      ly_q     <= ly_d;
    end
  end

  // Single-port line buffer; contents survive reset and are rewritten every even line
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_mem[lb_addr] <= lb_wdata;
    end else if (lb_re) begin
      lb_rd_q <= lb_mem[lb_addr];
    end
  end

endmodule

// File: tb/tb_chroma_resample.sv
// Directed bench for chroma_resample: 4x2 frames in each mode, backpressure,
// mid-frame mode change and mid-line reset.
module tb_chroma_resample;

  localparam int DW = 8;
  localparam int XW = 10;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] yuv_in [2:0];
  logic          yuv_in_valid, yuv_in_hold;
  logic          frame_valid_in, line_valid_in;
  logic [1:0]    mode;
  logic [XW-1:0] x_size_m1;
  logic [YW-1:0] y_size_m1;
  logic [DW-1:0] yuv_out [2:0];
  logic [2:0]    yuv_out_valid;
  logic          yuv_out_hold;
  logic          eof_out;
  logic [XW-1:0] yuv_out_pixel_count;
  logic [YW-1:0] yuv_out_line_count;

  chroma_resample #(.DW(DW), .SENSOR_X_SIZE(720), .SENSOR_Y_SIZE(720)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .yuv_in              (yuv_in),
    .yuv_in_valid        (yuv_in_valid),
    .yuv_in_hold         (yuv_in_hold),
    .frame_valid_in      (frame_valid_in),
    .line_valid_in       (line_valid_in),
    .mode                (mode),
    .x_size_m1           (x_size_m1),
    .y_size_m1           (y_size_m1),
    .yuv_out             (yuv_out),
    .yuv_out_valid       (yuv_out_valid),
    .yuv_out_hold        (yuv_out_hold),
    .eof_out             (eof_out),
    .yuv_out_pixel_count (yuv_out_pixel_count),
    .yuv_out_line_count  (yuv_out_line_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [7:0] y, cb, cr;
    logic [9:0] px, ly;
    logic       eof;
    int         cyc;
  } rec_t;

  rec_t recs[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   bp_en = 1'b0;
  logic [47:0] snap;
  bit   have_snap = 1'b0;

  logic [7:0] stim_cb [8];
  logic [7:0] stim_cr [8];
  int exp_v  [8];
  int exp_cb [8];
  int exp_cr [8];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] out_vec();
    return {yuv_out_valid, yuv_out[0], yuv_out[1], yuv_out[2],
            yuv_out_pixel_count, yuv_out_line_count, eof_out};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (resetn && frame_valid_in && (!x_size_m1[0] || !y_size_m1[0]))
      $error("frame dimensions must be even");

  // Random downstream backpressure
  always @(posedge clk) begin
    #2;
    if (bp_en) yuv_out_hold = 1'($urandom_range(0, 1));
  end

  // Output monitor: log consumed pixels, check stability of held outputs
  always @(negedge clk) begin
    if (have_snap) check_eq("stable_under_hold", out_vec(), snap);
    have_snap <= bp_en && resetn && (|yuv_out_valid) && yuv_out_hold;
    snap      <= out_vec();
    if (resetn && (|yuv_out_valid) && !yuv_out_hold)
      recs.push_back('{v: yuv_out_valid, y: yuv_out[0], cb: yuv_out[1], cr: yuv_out[2],
                       px: yuv_out_pixel_count, ly: yuv_out_line_count, eof: eof_out,
                       cyc: cyc});
  end

  task automatic send_pixel(input int idx);
    bit acc;
    yuv_in_valid = 1'b1;
    yuv_in[0]    = 8'(idx * 3 + 7);
    yuv_in[1]    = stim_cb[idx];
    yuv_in[2]    = stim_cr[idx];
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = !yuv_in_hold;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_frame(input logic [1:0] md, input logic [1:0] md_mid);
    recs.delete();
    mode           = md;
    frame_valid_in = 1'b1;
    for (int ln = 0; ln < 2; ln++) begin
      line_valid_in = 1'b1;
      for (int px = 0; px < 4; px++) begin
        send_pixel(ln * 4 + px);
        if (ln == 0 && px == 0) mode = md_mid;
      end
      yuv_in_valid  = 1'b0;
      line_valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    frame_valid_in = 1'b0;
    bp_en          = 1'b0;
    yuv_out_hold   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name);
    rec_t r;
    check_eq({name, ".count"}, 64'(recs.size()), 64'd8);
    for (int i = 0; i < 8 && i < recs.size(); i++) begin
      r = recs[i];
      check_eq($sformatf("%s.valid[%0d]", name, i), 64'(r.v), 64'(exp_v[i]));
      check_eq($sformatf("%s.y[%0d]", name, i), 64'(r.y), 64'(i * 3 + 7));
      if (exp_v[i] == 7) begin
        check_eq($sformatf("%s.cb[%0d]", name, i), 64'(r.cb), 64'(exp_cb[i]));
        check_eq($sformatf("%s.cr[%0d]", name, i), 64'(r.cr), 64'(exp_cr[i]));
      end
      check_eq($sformatf("%s.px[%0d]", name, i), 64'(r.px), 64'(i % 4));
      check_eq($sformatf("%s.ly[%0d]", name, i), 64'(r.ly), 64'(i / 4));
      check_eq($sformatf("%s.eof[%0d]", name, i), 64'(r.eof), 64'(i == 7));
    end
  endtask

  task automatic load_mode0();
    stim_cb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
    stim_cr = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205, 8'd206, 8'd207};
    exp_v   = '{7, 7, 7, 7, 7, 7, 7, 7};
    exp_cb  = '{1, 2, 3, 4, 1, 2, 3, 4};
    exp_cr  = '{200, 201, 202, 203, 204, 205, 206, 207};
  endtask

  initial begin
    resetn         = 1'b0;
    yuv_in[0]      = '0;
    yuv_in[1]      = '0;
    yuv_in[2]      = '0;
    yuv_in_valid   = 1'b0;
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    mode           = 2'd0;
    x_size_m1      = 10'd3;
    y_size_m1      = 10'd1;
    yuv_out_hold   = 1'b0;
    #2;
    check_eq("reset.valid", 64'(yuv_out_valid), 64'd0);
    check_eq("reset.eof", 64'(eof_out), 64'd0);
    check_eq("reset.hold", 64'(yuv_in_hold), 64'd0);
    check_eq("reset.y", 64'(yuv_out[0]), 64'd0);
    check_eq("reset.px", 64'(yuv_out_pixel_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 4:4:4 pass-through at full rate
    load_mode0();
    run_frame(2'd0, 2'd0);
    check_frame("m444");
    if (recs.size() == 8) begin
      check_eq("m444.rate_line0", 64'(recs[3].cyc - recs[0].cyc), 64'd3);
      check_eq("m444.rate_line1", 64'(recs[7].cyc - recs[4].cyc), 64'd3);
    end

    // 4:2:2 rounded pair average
    stim_cb = '{8'd10, 8'd21, 8'd30, 8'd41, 8'd5, 8'd6, 8'd7, 8'd8};
    stim_cr = '{8'd100, 8'd101, 8'd200, 8'd255, 8'd0, 8'd1, 8'd254, 8'd255};
    exp_v   = '{1, 7, 1, 7, 1, 7, 1, 7};
    exp_cb  = '{0, 16, 0, 36, 0, 6, 0, 8};
    exp_cr  = '{0, 101, 0, 228, 0, 1, 0, 255};
    run_frame(2'd1, 2'd1);
    check_frame("m422");

    // 4:0:0 with a mid-frame request for 4:2:0 that must be ignored
    exp_v = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_frame(2'd3, 2'd2);
    check_frame("m400");

    // 4:2:0 four-tap average through the line buffer
    stim_cb = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd11, 8'd21, 8'd31, 8'd41};
    stim_cr = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_v   = '{1, 1, 1, 1, 1, 7, 1, 7};
    exp_cb  = '{0, 0, 0, 0, 0, 16, 0, 36};
    exp_cr  = '{0, 0, 0, 0, 0, 3, 0, 5};
    run_frame(2'd2, 2'd2);
    check_frame("m420");

    // Same 4:2:0 frame under random backpressure
    bp_en = 1'b1;
    run_frame(2'd2, 2'd2);
    check_frame("m420_bp");

    // Reset in the middle of a 4:2:2 line
    load_mode0();
    recs.delete();
    mode           = 2'd1;
    frame_valid_in = 1'b1;
    line_valid_in  = 1'b1;
    send_pixel(0);
    send_pixel(1);
    yuv_in_valid = 1'b0;
    yuv_out_hold = 1'b1;
    #1;
    check_eq("pre_reset.valid", 64'(yuv_out_valid), 64'd7);
    check_eq("pre_reset.hold", 64'(yuv_in_hold), 64'd1);
    resetn = 1'b0;
    #1;
    check_eq("mid_reset.valid", 64'(yuv_out_valid), 64'd0);
    check_eq("mid_reset.y", 64'(yuv_out[0]), 64'd0);
    check_eq("mid_reset.cb", 64'(yuv_out[1]), 64'd0);
    check_eq("mid_reset.cr", 64'(yuv_out[2]), 64'd0);
    check_eq("mid_reset.px", 64'(yuv_out_pixel_count), 64'd0);
    check_eq("mid_reset.ly", 64'(yuv_out_line_count), 64'd0);
    check_eq("mid_reset.eof", 64'(eof_out), 64'd0);
    check_eq("mid_reset.hold", 64'(yuv_in_hold), 64'd0);
    frame_valid_in = 1'b0;
    line_valid_in  = 1'b0;
    yuv_out_hold   = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(2'd0, 2'd0);
    check_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
